// File: rtl/router_wrap_odata_egress.sv
// -----------------------------------------------------------------------------
// router_wrap_odata_egress
//
// Purpose:
//   Egress companion to the router_wrap slice IDATA flops. Flits from the router
//   output channel are taken over a valid/ready handshake into a small FIFO and
//   sent out as registered ODATA flits. Each flit sent costs one downstream
//   credit, and the downstream tile returns credits as single-cycle pulses.
//
// Ports:
//   clk           in   block clock, rising edge
//   reset         in   asynchronous, active-high reset
//   rtr_valid     in   router presents a flit
//   rtr_data      in   router flit payload [DATA_W]
//   rtr_ready     out  block accepts a flit this cycle
//   odata_valid   out  registered one-cycle pulse per flit sent
//   odata         out  registered flit payload [DATA_W]
//   credit_in     in   one-cycle pulse, one credit returned downstream
//   credit_cnt    out  available downstream credits [4]
//   fifo_cnt      out  FIFO occupancy [clog2(DEPTH)+1]
//   overflow_err  out  sticky flag, a credit was returned beyond CREDITS
// -----------------------------------------------------------------------------
module router_wrap_odata_egress #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int CREDITS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rtr_valid,
   input  logic [DATA_W-1:0]         rtr_data,
   output logic                      rtr_ready,
   output logic                      odata_valid,
   output logic [DATA_W-1:0]         odata,
   input  logic                      credit_in,
   output logic [3:0]                credit_cnt,
   output logic [$clog2(DEPTH):0]    fifo_cnt,
   output logic                      overflow_err
);

   localparam int              AW        = $clog2(DEPTH);
   localparam logic [AW:0]     DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [3:0]      CREDITS_C = 4'(CREDITS);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_fifo_cnt;
   logic [3:0]        r_credit_cnt;
   logic              r_odata_valid;
   logic [DATA_W-1:0] r_odata;
   logic              r_overflow_err;

   logic              w_push;
   logic              w_pop;
   logic [3:0]        w_credit_next;
   logic              w_ovf_set;
   logic [AW:0]       w_fifo_next;

   // Ready looks only at registered occupancy, so a full FIFO refuses a flit
   // even in a cycle where it also pops.
   assign rtr_ready = (r_fifo_cnt < DEPTH_C) & ~reset;
   assign w_push    = rtr_valid & rtr_ready;
   // Pop uses registered credits only; a credit returned this cycle counts next cycle.
   assign w_pop     = (r_fifo_cnt != '0) & (r_credit_cnt != 4'd0);

   assign w_fifo_next = r_fifo_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_comb begin
      w_credit_next = r_credit_cnt;
      w_ovf_set     = 1'b0;
      if (credit_in && !w_pop && (r_credit_cnt == CREDITS_C)) begin
         // Extra credit from downstream: saturate and flag it.
         w_ovf_set = 1'b1;
      end else begin
         w_credit_next = r_credit_cnt - {3'b000, w_pop} + {3'b000, credit_in};
      end
   end

   // Storage has no reset; occupancy and pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rtr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_fifo_cnt     <= '0;
         r_credit_cnt   <= CREDITS_C;
         r_odata_valid  <= 1'b0;
         r_odata        <= '0;
         r_overflow_err <= 1'b0;
      end else begin
         r_fifo_cnt    <= w_fifo_next;
         r_credit_cnt  <= w_credit_next;
         r_odata_valid <= w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_odata  <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_ovf_set) begin
            r_overflow_err <= 1'b1;
         end
      end
   end

   assign odata_valid  = r_odata_valid;
   assign odata        = r_odata;
   assign credit_cnt   = r_credit_cnt;
   assign fifo_cnt     = r_fifo_cnt;
   assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_router_wrap_odata_egress.sv
// -----------------------------------------------------------------------------
// tb_router_wrap_odata_egress
//
// Directed bench for router_wrap_odata_egress with DATA_W=32, DEPTH=4 and
// CREDITS=4. Inputs change 1 ns after each rising edge, and outputs are looked
// at in that same window.
// -----------------------------------------------------------------------------
module tb_router_wrap_odata_egress;

   logic        clk;
   logic        reset;
   logic        rtr_valid;
   logic [31:0] rtr_data;
   logic        rtr_ready;
   logic        odata_valid;
   logic [31:0] odata;
   logic        credit_in;
   logic [3:0]  credit_cnt;
   logic [2:0]  fifo_cnt;
   logic        overflow_err;

   int checks   = 0;
   int failures = 0;

   router_wrap_odata_egress #(
      .DATA_W (32),
      .DEPTH  (4),
      .CREDITS(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rtr_valid   (rtr_valid),
      .rtr_data    (rtr_data),
      .rtr_ready   (rtr_ready),
      .odata_valid (odata_valid),
      .odata       (odata),
      .credit_in   (credit_in),
      .credit_cnt  (credit_cnt),
      .fifo_cnt    (fifo_cnt),
      .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int          pulses;
      logic [31:0] exp_data;

      reset     = 1'b1;
      rtr_valid = 1'b0;
      rtr_data  = '0;
      credit_in = 1'b0;
      step();
      step();

      // ---------------- reset state
      check("rst_fifo_cnt", fifo_cnt, 0);
      check("rst_credit", credit_cnt, 4);
      check("rst_ovalid", odata_valid, 0);
      check("rst_odata", odata, 0);
      check("rst_ovf", overflow_err, 0);
      check("rst_ready", rtr_ready, 0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", rtr_ready, 1);

      // ---------------- single flit
      rtr_valid = 1'b1;
      rtr_data  = 32'hA5A5_0001;
      step();
      rtr_valid = 1'b0;
      rtr_data  = 32'hFFFF_FFFF;
      check("single_fifo1", fifo_cnt, 1);
      check("single_noval_yet", odata_valid, 0);
      step();
      check("single_ovalid", odata_valid, 1);
      check("single_odata", odata, 32'hA5A5_0001);
      check("single_credit", credit_cnt, 3);
      check("single_fifo0", fifo_cnt, 0);
      step();
      check("single_pulse_end", odata_valid, 0);
      check("single_odata_hold", odata, 32'hA5A5_0001);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("single_credit_back", credit_cnt, 4);

      // ---------------- burst of 6 with no credit returns
      pulses   = 0;
      exp_data = 32'h1;
      for (int i = 0; i < 10; i++) begin
         rtr_valid = (i < 6);
         rtr_data  = 32'(i + 1);
         step();
         if (odata_valid) begin
            check("burst_data", odata, exp_data);
            exp_data = exp_data + 1;
            pulses++;
         end
      end
      rtr_valid = 1'b0;
      check("burst_pulses", pulses, 4);
      check("burst_credit0", credit_cnt, 0);
      check("burst_fifo2", fifo_cnt, 2);
      check("burst_ready", rtr_ready, 1);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("burst_cr1_nopop", odata_valid, 0);
      check("burst_cr1", credit_cnt, 1);
      step();
      check("burst_v5", odata_valid, 1);
      check("burst_d5", odata, 32'h5);
      check("burst_cr_after5", credit_cnt, 0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("burst_gap", odata_valid, 0);
      step();
      check("burst_v6", odata_valid, 1);
      check("burst_d6", odata, 32'h6);
      check("burst_cr_end", credit_cnt, 0);
      check("burst_fifo_end", fifo_cnt, 0);

      // ---------------- fill to full with no credits
      for (int i = 0; i < 4; i++) begin
         rtr_valid = 1'b1;
         rtr_data  = 32'h10 + 32'(i);
         step();
      end
      check("full_cnt", fifo_cnt, 4);
      check("full_ready", rtr_ready, 0);
      rtr_data = 32'h0000_0BAD;
      step();
      rtr_valid = 1'b0;
      check("full_reject_cnt", fifo_cnt, 4);
      check("full_no_out", odata_valid, 0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("full_credit1", credit_cnt, 1);
      check("full_still_full", rtr_ready, 0);
      step();
      check("full_pop_v", odata_valid, 1);
      check("full_pop_d", odata, 32'h10);
      check("full_pop_cnt", fifo_cnt, 3);
      check("full_ready_back", rtr_ready, 1);
      check("full_credit0", credit_cnt, 0);
      pulses   = 0;
      exp_data = 32'h11;
      for (int i = 0; i < 8; i++) begin
         credit_in = (i < 3);
         step();
         if (odata_valid) begin
            check("drain_data", odata, exp_data);
            exp_data = exp_data + 1;
            pulses++;
         end
      end
      credit_in = 1'b0;
      check("drain_pulses", pulses, 3);
      check("drain_fifo", fifo_cnt, 0);
      credit_in = 1'b1;
      repeat (4) step();
      credit_in = 1'b0;
      check("restore_credit", credit_cnt, 4);
      check("restore_no_ovf", overflow_err, 0);

      // ---------------- stream with pop and credit return together
      exp_data = 32'h100;
      for (int i = 0; i < 12; i++) begin
         rtr_valid = (i < 10);
         rtr_data  = 32'h100 + 32'(i);
         credit_in = (i >= 1) && (i <= 10);
         step();
         check("stream_credit", credit_cnt, 4);
         check("stream_valid", odata_valid, ((i >= 1) && (i <= 10)) ? 1 : 0);
         if (odata_valid) begin
            check("stream_data", odata, exp_data);
            exp_data = exp_data + 1;
         end
      end
      rtr_valid = 1'b0;
      credit_in = 1'b0;
      check("stream_fifo_end", fifo_cnt, 0);
      check("stream_no_ovf", overflow_err, 0);

      // ---------------- credit overflow
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("ovf_credit_sat", credit_cnt, 4);
      check("ovf_set", overflow_err, 1);
      for (int i = 0; i < 20; i++) begin
         step();
         check("ovf_held", overflow_err, 1);
      end
      #3;
      reset = 1'b1;
      #1;
      check("ovf_cleared", overflow_err, 0);
      step();
      reset = 1'b0;

      // ---------------- reset mid-stream
      for (int i = 0; i < 4; i++) begin
         rtr_valid = 1'b1;
         rtr_data  = 32'hD0 + 32'(i);
         step();
      end
      rtr_valid = 1'b0;
      repeat (3) step();
      check("mid_credit0", credit_cnt, 0);
      check("mid_last_odata", odata, 32'hD3);
      for (int i = 0; i < 3; i++) begin
         rtr_valid = 1'b1;
         rtr_data  = 32'hE0 + 32'(i);
         step();
      end
      rtr_valid = 1'b0;
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      check("mid_fifo3", fifo_cnt, 3);
      check("mid_credit1", credit_cnt, 1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_odata", odata, 0);
      check("mid_rst_ovalid", odata_valid, 0);
      check("mid_rst_fifo", fifo_cnt, 0);
      check("mid_rst_credit", credit_cnt, 4);
      check("mid_rst_ready", rtr_ready, 0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("mid_no_stale_v", odata_valid, 0);
         check("mid_no_stale_d", odata, 0);
      end
      check("mid_final_credit", credit_cnt, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
